// File: rtl/data_path.sv
// Phase-1 single-bus CPU datapath: sixteen GPRs, HI/LO, PC, MDR, Y, 64-bit Z,
// a combinational ALU and a priority bus multiplexer, all driven by strobes.
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] regIn,
    input  logic        HiIn,
    input  logic        LoIn,
    input  logic        ZIn,
    input  logic        PCIn,
    input  logic        MDRIn,
    input  logic        YIn,
    input  logic [15:0] regOut,
    input  logic        HiOut,
    input  logic        LoOut,
    input  logic        ZHiOut,
    input  logic        ZLoOut,
    input  logic        PCOut,
    input  logic        MDROut,
    input  logic [31:0] Mdata,
    input  logic        MDRread,
    input  logic [4:0]  ALUcode,
    input  logic [31:0] temp,
    input  logic        tempEnable
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_DIV  = 5'b01111,
        OP_MUL  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } alu_op_e;

    logic [31:0] r [16];
    logic [31:0] hi, lo, pc, mdr, y;
    logic [63:0] z;
    logic [31:0] bus_mux_out;

    logic [31:0] alu_hi, alu_lo;
    logic [4:0]  sh;
    logic [63:0] ror_full, rol_full;
    logic signed [63:0] product;
    alu_op_e     op;

    // Bus source priority: injected value, then lowest-numbered GPR, then specials.
    always_comb begin
        bus_mux_out = '0;
        if (tempEnable) begin
            bus_mux_out = temp;
        end else if (|regOut) begin
            for (int i = 15; i >= 0; i--) begin
                if (regOut[i]) bus_mux_out = r[i];
            end
        end else if (HiOut) begin
            bus_mux_out = hi;
        end else if (LoOut) begin
            bus_mux_out = lo;
        end else if (ZHiOut) begin
            bus_mux_out = z[63:32];
        end else if (ZLoOut) begin
            bus_mux_out = z[31:0];
        end else if (PCOut) begin
            bus_mux_out = pc;
        end else if (MDROut) begin
            bus_mux_out = mdr;
        end
    end

    assign op       = alu_op_e'(ALUcode);
    assign sh       = bus_mux_out[4:0];
    // Rotations fall out of shifting a doubled copy of A.
    assign ror_full = {y, y} >> sh;
    assign rol_full = {y, y} << sh;
    assign product  = $signed({{32{y[31]}}, y}) * $signed({{32{bus_mux_out[31]}}, bus_mux_out});

    // NOTE: both outputs get a default before the case so no path can infer a latch.
    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (op)
            OP_ADD:  alu_lo = y + bus_mux_out;
            OP_SUB:  alu_lo = y - bus_mux_out;
            OP_AND:  alu_lo = y & bus_mux_out;
            OP_OR:   alu_lo = y | bus_mux_out;
            OP_ROR:  alu_lo = ror_full[31:0];
            OP_ROL:  alu_lo = rol_full[63:32];
            OP_SHR:  alu_lo = y >> sh;
            OP_SHRA: alu_lo = $signed(y) >>> sh;
            OP_SHL:  alu_lo = y << sh;
            OP_DIV: begin
                if (bus_mux_out == 32'd0) begin
                    alu_lo = '1;
                    alu_hi = y;
                end else begin
                    alu_lo = $signed(y) / $signed(bus_mux_out);
                    alu_hi = $signed(y) % $signed(bus_mux_out);
                end
            end
            OP_MUL:  {alu_hi, alu_lo} = product;
            OP_NEG:  alu_lo = -bus_mux_out;
            OP_NOT:  alu_lo = ~bus_mux_out;
            default: begin
                alu_hi = '0;
                alu_lo = '0;
            end
        endcase
    end

    // NOTE: the register file is reset too; it is small and software expects zeros after clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            hi  <= '0;
            lo  <= '0;
            pc  <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (regIn[i]) r[i] <= bus_mux_out;
            end
            if (HiIn)  hi  <= bus_mux_out;
            if (LoIn)  lo  <= bus_mux_out;
            if (PCIn)  pc  <= bus_mux_out;
            if (MDRIn) mdr <= MDRread ? Mdata : bus_mux_out;
            if (YIn)   y   <= bus_mux_out;
            if (ZIn)   z   <= {alu_hi, alu_lo};
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: a behavioural model is compared against every
// internal register each cycle, plus literal checks from hand-worked sequences.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] regIn = '0, regOut = '0;
    logic        HiIn = 0, LoIn = 0, ZIn = 0, PCIn = 0, MDRIn = 0, YIn = 0;
    logic        HiOut = 0, LoOut = 0, ZHiOut = 0, ZLoOut = 0, PCOut = 0, MDROut = 0;
    logic [31:0] Mdata = '0, temp = '0;
    logic        MDRread = 0, tempEnable = 0;
    logic [4:0]  ALUcode = '0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_pc, m_mdr, m_y;
    logic [63:0] m_z;

    data_path dut (
        .clock(clock), .clear(clear), .regIn(regIn),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .YIn(YIn),
        .regOut(regOut), .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .Mdata(Mdata), .MDRread(MDRread),
        .ALUcode(ALUcode), .temp(temp), .tempEnable(tempEnable)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the bus must carry given the strobes and model state.
    function automatic logic [31:0] ref_bus();
        if (tempEnable) return temp;
        for (int i = 0; i < 16; i++) if (regOut[i]) return m_r[i];
        if (HiOut)  return m_hi;
        if (LoOut)  return m_lo;
        if (ZHiOut) return m_z[63:32];
        if (ZLoOut) return m_z[31:0];
        if (PCOut)  return m_pc;
        if (MDROut) return m_mdr;
        return 32'd0;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] v;
        longint p;
        n = int'(b[4:0]);
        v = a;
        case (code)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  begin for (int k = 0; k < n; k++) v = {v[0], v[31:1]};  return {32'd0, v}; end
            5'd8:  begin for (int k = 0; k < n; k++) v = {v[30:0], v[31]};  return {32'd0, v}; end
            5'd9:  begin for (int k = 0; k < n; k++) v = {1'b0, v[31:1]};  return {32'd0, v}; end
            5'd10: begin for (int k = 0; k < n; k++) v = {v[31], v[31:1]}; return {32'd0, v}; end
            5'd11: begin for (int k = 0; k < n; k++) v = {v[30:0], 1'b0};  return {32'd0, v}; end
            5'd15: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            5'd16: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            5'd17: return {32'd0, 32'd0 - b};
            5'd18: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] <= '0;
            m_hi <= '0; m_lo <= '0; m_pc <= '0; m_mdr <= '0; m_y <= '0; m_z <= '0;
        end else begin
            for (int i = 0; i < 16; i++) if (regIn[i]) m_r[i] <= ref_bus();
            if (HiIn)  m_hi  <= ref_bus();
            if (LoIn)  m_lo  <= ref_bus();
            if (PCIn)  m_pc  <= ref_bus();
            if (MDRIn) m_mdr <= MDRread ? Mdata : ref_bus();
            if (YIn)   m_y   <= ref_bus();
            if (ZIn)   m_z   <= ref_alu(ALUcode, m_y, ref_bus());
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < 16; i++) check($sformatf("r%0d", i), {32'd0, dut.r[i]}, {32'd0, m_r[i]});
            check("hi",  {32'd0, dut.hi},  {32'd0, m_hi});
            check("lo",  {32'd0, dut.lo},  {32'd0, m_lo});
            check("pc",  {32'd0, dut.pc},  {32'd0, m_pc});
            check("mdr", {32'd0, dut.mdr}, {32'd0, m_mdr});
            check("y",   {32'd0, dut.y},   {32'd0, m_y});
            check("z",   dut.z, m_z);
            check("bus", {32'd0, dut.bus_mux_out}, {32'd0, ref_bus()});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        regIn = '0; regOut = '0;
        HiIn = 0; LoIn = 0; ZIn = 0; PCIn = 0; MDRIn = 0; YIn = 0;
        HiOut = 0; LoOut = 0; ZHiOut = 0; ZLoOut = 0; PCOut = 0; MDROut = 0;
        MDRread = 0; tempEnable = 0; ALUcode = '0;
    endtask

    task automatic put(input logic [31:0] v, input logic [15:0] dst);
        idle(); temp = v; tempEnable = 1; regIn = dst; tick(); idle();
    endtask

    // Load Y with a, then run code with B = b into Z.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] code);
        idle(); temp = a; tempEnable = 1; YIn = 1; tick();
        idle(); temp = b; tempEnable = 1; ZIn = 1; ALUcode = code; tick(); idle();
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] acc;
        acc = dut.hi | dut.lo | dut.pc | dut.mdr | dut.y | dut.z[63:32] | dut.z[31:0];
        for (int i = 0; i < 16; i++) acc = acc | dut.r[i];
        check(tag, {32'd0, acc}, 64'd0);
    endtask

    initial begin
        #1 clear = 1;
        #2 check_all_zero("reset_state");
        tick();
        clear = 0;
        cmp_en = 1;

        // AND sequence
        put(32'hA, 16'h0008);
        put(32'hF, 16'h0080);
        idle(); regOut[3] = 1; YIn = 1; tick();
        idle(); regOut[7] = 1; ZIn = 1; ALUcode = 5'b00101; tick();
        check("and_z", dut.z, 64'h0000_0000_0000_000A);
        idle(); ZLoOut = 1; regIn[4] = 1; tick(); idle();
        check("and_r4", {32'd0, dut.r[4]}, 64'hA);

        // MDR from memory, then MDR to PC
        idle(); Mdata = 32'h28A3_8000; MDRread = 1; MDRIn = 1; tick();
        check("mdr_load", {32'd0, dut.mdr}, 64'h28A3_8000);
        idle(); MDROut = 1; PCIn = 1; tick(); idle();
        check("pc_from_mdr", {32'd0, dut.pc}, 64'h28A3_8000);

        // MUL / DIV
        alu_op(32'hFFFF_FFFA, 32'd4, 5'b10000);
        check("mul", dut.z, 64'hFFFF_FFFF_FFFF_FFE8);
        idle(); ZHiOut = 1; HiIn = 1; tick(); idle();
        check("hi_from_z", {32'd0, dut.hi}, 64'hFFFF_FFFF);
        alu_op(32'd7, 32'd2, 5'b01111);
        check("div", dut.z, 64'h0000_0001_0000_0003);
        alu_op(32'd7, 32'd0, 5'b01111);
        check("div_by_zero", dut.z, 64'h0000_0007_FFFF_FFFF);
        alu_op(32'hFFFF_FFF9, 32'd2, 5'b01111);
        check("div_neg", dut.z, 64'hFFFF_FFFF_FFFF_FFFD);

        // Shifts and rotates, A = 0x80000001, B = 1
        alu_op(32'h8000_0001, 32'd1, 5'b01001); check("shr",  dut.z, 64'h4000_0000);
        alu_op(32'h8000_0001, 32'd1, 5'b01010); check("shra", dut.z, 64'hC000_0000);
        alu_op(32'h8000_0001, 32'd1, 5'b01011); check("shl",  dut.z, 64'h0000_0002);
        alu_op(32'h8000_0001, 32'd1, 5'b00111); check("ror",  dut.z, 64'hC000_0000);
        alu_op(32'h8000_0001, 32'd1, 5'b01000); check("rol",  dut.z, 64'h0000_0003);
        alu_op(32'h8000_0001, 32'd32, 5'b01000); check("rol_b32", dut.z, 64'h8000_0001);
        alu_op(32'h8000_0001, 32'd32, 5'b01010); check("shra_b32", dut.z, 64'h8000_0001);
        alu_op(32'h1234_5678, 32'd8, 5'b00111); check("ror_8", dut.z, 64'h7812_3456);

        // Arithmetic edges and unused codes
        alu_op(32'hFFFF_FFFF, 32'd1, 5'b00011); check("add_wrap", dut.z, 64'd0);
        alu_op(32'd0, 32'd1, 5'b00100);         check("sub_wrap", dut.z, 64'h0000_0000_FFFF_FFFF);
        alu_op(32'd9, 32'd5, 5'b10001);         check("neg", dut.z, 64'h0000_0000_FFFF_FFFB);
        alu_op(32'd9, 32'd0, 5'b10010);         check("not", dut.z, 64'h0000_0000_FFFF_FFFF);
        alu_op(32'hF0F0_0000, 32'h0000_0F0F, 5'b00110); check("or", dut.z, 64'h0000_0000_F0F0_0F0F);
        alu_op(32'h1234_5678, 32'h1, 5'b00000); check("bad_code", dut.z, 64'd0);

        // Same-register in/out and multiple In strobes on one edge
        idle(); regOut[4] = 1; regIn[4] = 1; regIn[9] = 1; LoIn = 1; YIn = 1; tick(); idle();
        check("multi_in_r9", {32'd0, dut.r[9]}, 64'hA);
        check("multi_in_lo", {32'd0, dut.lo}, 64'hA);
        idle(); regOut[4] = 1; ZIn = 1; ALUcode = 5'b00011; regIn[4] = 1; tick(); idle();
        check("in_out_same", {32'd0, dut.r[4]}, 64'hA);
        check("add_self", dut.z, 64'h14);

        // Bus priority
        put(32'h11, 16'h0002);
        put(32'h22, 16'h0004);
        put(32'h55, 16'h0020);
        idle(); regOut = 16'h0022; #1;
        check("bus_low_index", {32'd0, dut.bus_mux_out}, 64'h11);
        tempEnable = 1; temp = 32'h99; regOut = 16'h0004; #1;
        check("bus_temp_first", {32'd0, dut.bus_mux_out}, 64'h99);
        idle(); LoOut = 1; PCOut = 1; #1;
        check("bus_lo_over_pc", {32'd0, dut.bus_mux_out}, 64'hA);
        idle(); #1;
        check("bus_none", {32'd0, dut.bus_mux_out}, 64'd0);
        tick();

        // Asynchronous clear between edges, with a load pending
        idle(); temp = 32'h77; tempEnable = 1; regIn = 16'hFFFF;
        clear = 1; #1;
        check_all_zero("async_clear");
        clear = 0; idle(); #1;
        check("bus_after_clear", {32'd0, dut.bus_mux_out}, 64'd0);
        tick();
        put(32'h3C, 16'h0001);
        check("r0_after_clear", {32'd0, dut.r[0]}, 64'h3C);
        tick();
        tick();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
